lc4_arith_scheduler: RTL and testbench
======================================

LC4_ARITH_SCHEDULER -- requirements
Module: lc4_arith_scheduler

Interface
REQ-001 Parameter NUM_ENTRIES, default 4: reservation-station depth; legal values 2..8.
REQ-002 Parameter TAG_W, default 4: physical-register tag width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 disp_valid  in  1  dispatch request.
REQ-006 disp_ready  out  1  station can accept a dispatch.
REQ-007 disp_insn, disp_pc  in  16 each  instruction word and its PC.
REQ-008 disp_src1_tag, disp_src2_tag  in  TAG_W each  source tags.
REQ-009 disp_src1_rdy, disp_src2_rdy  in  1 each  source value already available.
REQ-010 disp_src1_data, disp_src2_data  in  16 each  source values, meaningful when matching rdy=1.
REQ-011 disp_dst_tag  in  TAG_W  destination tag, carried through to issue.
REQ-012 wb_valid  in  1; wb_tag  in  TAG_W; wb_data  in  16  result broadcast used for wakeup.
REQ-013 flush  in  1  discard all held entries.
REQ-014 iss_valid  out  1; iss_ready  in  1  issue handshake toward the arithmetic stage.
REQ-015 iss_insn, iss_pc, iss_r1data, iss_r2data  out  16 each; iss_dst_tag  out  TAG_W  issued operation.
REQ-016 count  out  clog2(NUM_ENTRIES+1)  number of valid entries.

Function
REQ-017 Each entry SHALL hold valid, insn, pc, dst_tag, and per source: tag, rdy, data.
REQ-018 disp_ready SHALL be 1 when count < NUM_ENTRIES and flush=0; it SHALL NOT depend on iss_ready in the same cycle.
REQ-019 A dispatch SHALL occur when disp_valid && disp_ready; the entry is written at that edge and is youngest.
REQ-020 An entry is eligible when valid and both source rdy=1; iss_valid SHALL be 1 when any entry is eligible and flush=0.
REQ-021 iss_* outputs SHALL come combinationally from the oldest eligible entry (earliest dispatched); iss_r1data/iss_r2data = src1/src2 data.
REQ-022 An issue occurs when iss_valid && iss_ready; that entry is removed at the edge; relative age of the remaining entries is preserved.
REQ-023 While iss_valid=1 and iss_ready=0, iss_* SHALL remain stable unless an older entry becomes eligible through wakeup.
REQ-024 Wakeup: on wb_valid, every held source with rdy=0 and tag==wb_tag SHALL set rdy=1 and capture wb_data at the edge.
REQ-025 The entry SHALL become eligible the cycle after the wakeup edge; there is no same-cycle issue from wb.
REQ-026 Dispatch bypass: if wb_valid and wb_tag equals a dispatching source tag with rdy=0, the entry SHALL be written with rdy=1 and data=wb_data.
REQ-027 Minimum latency is one cycle: an operation dispatched ready at edge E SHALL be presentable on iss_* in the cycle after E.
REQ-028 Simultaneous dispatch and issue SHALL leave count unchanged; at full, a same-cycle issue SHALL NOT enable dispatch (REQ-018).
REQ-029 wb with no matching tag SHALL be ignored; sources already rdy=1 SHALL NOT be overwritten.
REQ-030 flush=1 SHALL clear all valid bits at the next edge, block dispatch, and force iss_valid=0 during that cycle.
REQ-031 count SHALL equal the population of valid bits and never exceed NUM_ENTRIES.

Reset
REQ-032 While rst_n=0: all valid bits, count, and iss_valid SHALL be 0, and disp_ready SHALL be 1; entry payload fields are don't-care.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately; the first dispatch is accepted on the first rising edge after deassertion.

Structure
REQ-034 The shared package lc4_ooo_pkg SHALL hold the TAG_W and NUM_ENTRIES defaults and the station-entry record type.
REQ-035 Oldest-eligible selection SHALL be a sub-module, lc4_age_select, taking eligible and age vectors and producing a one-hot grant.

Verification
REQ-036 Reset: rst_n=0 -> count=0, iss_valid=0, disp_ready=1; dispatch insn 0x1283 with both sources rdy -> iss_insn=0x1283 in the next cycle.
REQ-037 Age order: dispatch A (pc 0x0010) and B (pc 0x0011), both ready, iss_ready=1 -> A issues before B.
REQ-038 Wakeup: dispatch with src1 tag=5 not ready, then wb_valid, tag=5, data=0xBEEF -> iss_valid=1 one cycle later with iss_r1data=0xBEEF.
REQ-039 Full/backpressure: fill 4 entries with iss_ready=0 -> disp_ready=0, count=4, iss_* stable; then iss_ready=1 for one cycle -> count=3, disp_ready=1.
REQ-040 Bypass: dispatch src2 tag=3 not ready in the same cycle as wb tag=3, data=0x0042 -> issues next cycle with iss_r2data=0x0042.
REQ-041 Flush: 3 entries held, flush=1 with disp_valid=1 -> iss_valid=0 in that cycle, count=0 next cycle, and the dispatch is dropped.

Source files
------------

// File: rtl/lc4_ooo_pkg.sv
// rtl/lc4_ooo_pkg.sv - shared defaults, station-entry record and wakeup helpers
package lc4_ooo_pkg;

  localparam int DEF_NUM_ENTRIES = 4;
  localparam int DEF_TAG_W       = 4;
  // Tags are stored zero-extended to this width so one record type serves any TAG_W up to it.
  localparam int TAG_MAX_W       = 8;
  localparam int DATA_W          = 16;

  typedef struct packed {
    logic [TAG_MAX_W-1:0] tag;
    logic                 rdy;
    logic [DATA_W-1:0]    data;
  } rs_src_t;

  typedef struct packed {
    logic                 valid;
    logic [DATA_W-1:0]    insn;
    logic [DATA_W-1:0]    pc;
    logic [TAG_MAX_W-1:0] dst_tag;
    rs_src_t              src1;
    rs_src_t              src2;
  } rs_entry_t;

  // A waiting source matching the broadcast tag captures the result; ready sources are left alone.
  function automatic rs_src_t wake_src(input rs_src_t src, input logic wb_valid,
                                       input logic [TAG_MAX_W-1:0] wb_tag,
                                       input logic [DATA_W-1:0] wb_data);
    rs_src_t res;
    res = src;
    if (wb_valid && !src.rdy && (src.tag == wb_tag)) begin
      res.rdy  = 1'b1;
      res.data = wb_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/lc4_age_select.sv
// rtl/lc4_age_select.sv - one-hot grant of the oldest eligible entry from an age matrix
module lc4_age_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]   eligible,
  input  logic [N*N-1:0] older,
  output logic [N-1:0]   grant
);

  logic [N-1:0] blocked;

  // older[j*N+i] set means entry j was dispatched before entry i.
  always_comb begin
    grant   = '0;
    blocked = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if ((j != i) && eligible[j] && older[j*N+i]) begin
          blocked[i] = 1'b1;
        end
      end
      grant[i] = eligible[i] && !blocked[i];
    end
  end

endmodule

// File: rtl/lc4_arith_scheduler.sv
// rtl/lc4_arith_scheduler.sv - arithmetic reservation station with wakeup, bypass and oldest-first issue
module lc4_arith_scheduler
  import lc4_ooo_pkg::*;
#(
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int TAG_W       = DEF_TAG_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  logic [15:0]                        disp_insn,
  input  logic [15:0]                        disp_pc,
  input  logic [TAG_W-1:0]                   disp_src1_tag,
  input  logic [TAG_W-1:0]                   disp_src2_tag,
  input  logic                               disp_src1_rdy,
  input  logic                               disp_src2_rdy,
  input  logic [15:0]                        disp_src1_data,
  input  logic [15:0]                        disp_src2_data,
  input  logic [TAG_W-1:0]                   disp_dst_tag,
  input  logic                               wb_valid,
  input  logic [TAG_W-1:0]                   wb_tag,
  input  logic [15:0]                        wb_data,
  input  logic                               flush,
  output logic                               iss_valid,
  input  logic                               iss_ready,
  output logic [15:0]                        iss_insn,
  output logic [15:0]                        iss_pc,
  output logic [15:0]                        iss_r1data,
  output logic [15:0]                        iss_r2data,
  output logic [TAG_W-1:0]                   iss_dst_tag,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   count
);

  localparam int CNT_W = $clog2(NUM_ENTRIES+1);

  rs_entry_t              entries_q [NUM_ENTRIES];
  rs_entry_t              entries_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older_q   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older_d   [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0]             valid_vec;
  logic [NUM_ENTRIES-1:0]             elig_vec;
  logic [NUM_ENTRIES-1:0]             alloc_vec;
  logic [NUM_ENTRIES-1:0]             grant_vec;
  logic [NUM_ENTRIES*NUM_ENTRIES-1:0] older_flat;
  logic [CNT_W-1:0]                   count_c;
  logic                               alloc_found;
  logic                               disp_fire;
  logic                               iss_fire;
  logic [TAG_MAX_W-1:0]               wb_tag_x;
  logic [TAG_MAX_W-1:0]               sel_dst;
  rs_entry_t                          new_entry;

  always_comb begin
    valid_vec   = '0;
    elig_vec    = '0;
    alloc_vec   = '0;
    alloc_found = 1'b0;
    count_c     = '0;
    older_flat  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      elig_vec[i]  = entries_q[i].valid && entries_q[i].src1.rdy && entries_q[i].src2.rdy;
      count_c      = count_c + CNT_W'(entries_q[i].valid);
      if (!entries_q[i].valid && !alloc_found) begin
        alloc_vec[i] = 1'b1;
        alloc_found  = 1'b1;
      end
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        older_flat[i*NUM_ENTRIES+j] = older_q[i][j];
      end
    end
  end

  lc4_age_select #(.N(NUM_ENTRIES)) u_age_select (
    .eligible (elig_vec),
    .older    (older_flat),
    .grant    (grant_vec)
  );

  assign count      = count_c;
  assign disp_ready = (count_c < CNT_W'(NUM_ENTRIES)) && !flush;
  assign iss_valid  = (|elig_vec) && !flush;
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_fire   = iss_valid && iss_ready;
  assign wb_tag_x   = TAG_MAX_W'(wb_tag);

  always_comb begin
    iss_insn   = '0;
    iss_pc     = '0;
    iss_r1data = '0;
    iss_r2data = '0;
    sel_dst    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (grant_vec[i]) begin
        iss_insn   = entries_q[i].insn;
        iss_pc     = entries_q[i].pc;
        iss_r1data = entries_q[i].src1.data;
        iss_r2data = entries_q[i].src2.data;
        sel_dst    = entries_q[i].dst_tag;
      end
    end
    iss_dst_tag = sel_dst[TAG_W-1:0];
  end

  // A dispatching source waiting on the tag being broadcast this cycle is captured directly.
  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.insn       = disp_insn;
    new_entry.pc         = disp_pc;
    new_entry.dst_tag    = TAG_MAX_W'(disp_dst_tag);
    new_entry.src1.tag   = TAG_MAX_W'(disp_src1_tag);
    new_entry.src1.rdy   = disp_src1_rdy;
    new_entry.src1.data  = disp_src1_data;
    new_entry.src2.tag   = TAG_MAX_W'(disp_src2_tag);
    new_entry.src2.rdy   = disp_src2_rdy;
    new_entry.src2.data  = disp_src2_data;
    new_entry.src1       = wake_src(new_entry.src1, wb_valid, wb_tag_x, wb_data);
    new_entry.src2       = wake_src(new_entry.src2, wb_valid, wb_tag_x, wb_data);
  end

  always_comb begin
    entries_d = entries_q;
    older_d   = older_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entries_d[i].src1 = wake_src(entries_q[i].src1, wb_valid, wb_tag_x, wb_data);
      entries_d[i].src2 = wake_src(entries_q[i].src2, wb_valid, wb_tag_x, wb_data);
      if (iss_fire && grant_vec[i]) begin
        entries_d[i].valid = 1'b0;
      end
      // New entry is younger than everything already held.
      if (disp_fire && alloc_vec[i]) begin
        entries_d[i] = new_entry;
        older_d[i]   = '0;
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          if (j != i) begin
            older_d[j][i] = 1'b1;
          end
        end
      end
      if (flush) begin
        entries_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[i] <= '0;
        older_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[i] <= entries_d[i];
        older_q[i]   <= older_d[i];
      end
    end
  end

endmodule

// File: tb/tb_lc4_arith_scheduler.sv
// tb/tb_lc4_arith_scheduler.sv - directed self-checking bench for lc4_arith_scheduler
module tb_lc4_arith_scheduler;

  logic        clk;
  logic        rst_n;
  logic        disp_valid;
  logic        disp_ready;
  logic [15:0] disp_insn;
  logic [15:0] disp_pc;
  logic [3:0]  disp_src1_tag;
  logic [3:0]  disp_src2_tag;
  logic        disp_src1_rdy;
  logic        disp_src2_rdy;
  logic [15:0] disp_src1_data;
  logic [15:0] disp_src2_data;
  logic [3:0]  disp_dst_tag;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [15:0] wb_data;
  logic        flush;
  logic        iss_valid;
  logic        iss_ready;
  logic [15:0] iss_insn;
  logic [15:0] iss_pc;
  logic [15:0] iss_r1data;
  logic [15:0] iss_r2data;
  logic [3:0]  iss_dst_tag;
  logic [2:0]  count;

  int n_assert;
  int n_fail;

  lc4_arith_scheduler #(.NUM_ENTRIES(4), .TAG_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_insn      (disp_insn),
    .disp_pc        (disp_pc),
    .disp_src1_tag  (disp_src1_tag),
    .disp_src2_tag  (disp_src2_tag),
    .disp_src1_rdy  (disp_src1_rdy),
    .disp_src2_rdy  (disp_src2_rdy),
    .disp_src1_data (disp_src1_data),
    .disp_src2_data (disp_src2_data),
    .disp_dst_tag   (disp_dst_tag),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .wb_data        (wb_data),
    .flush          (flush),
    .iss_valid      (iss_valid),
    .iss_ready      (iss_ready),
    .iss_insn       (iss_insn),
    .iss_pc         (iss_pc),
    .iss_r1data     (iss_r1data),
    .iss_r2data     (iss_r2data),
    .iss_dst_tag    (iss_dst_tag),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wb_valid   = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic disp(input logic [15:0] insn, input logic [15:0] pc,
                      input logic [3:0] t1, input logic r1, input logic [15:0] d1,
                      input logic [3:0] t2, input logic r2, input logic [15:0] d2,
                      input logic [3:0] dst);
    disp_valid     = 1'b1;
    disp_insn      = insn;
    disp_pc        = pc;
    disp_src1_tag  = t1;
    disp_src1_rdy  = r1;
    disp_src1_data = d1;
    disp_src2_tag  = t2;
    disp_src2_rdy  = r2;
    disp_src2_data = d2;
    disp_dst_tag   = dst;
  endtask

  task automatic wb(input logic [3:0] tag, input logic [15:0] data);
    wb_valid = 1'b1;
    wb_tag   = tag;
    wb_data  = data;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    iss_ready = 1'b0;
    idle();
    disp(16'h0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);
    disp_valid = 1'b0;
    wb_tag  = 4'h0;
    wb_data = 16'h0;

    #12;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_iss_valid", 32'(iss_valid), 32'd1 - 32'd1);
    chk("reset_disp_ready", 32'(disp_ready), 32'd1);

    rst_n = 1'b1;
    disp(16'h1283, 16'h0100, 4'h1, 1'b1, 16'h0001, 4'h2, 1'b1, 16'h0002, 4'h7);
    cyc();
    idle();
    #1;
    chk("first_iss_valid", 32'(iss_valid), 32'd1);
    chk("first_iss_insn", 32'(iss_insn), 32'h1283);
    chk("first_r1data", 32'(iss_r1data), 32'h0001);
    chk("first_r2data", 32'(iss_r2data), 32'h0002);
    chk("first_dst_tag", 32'(iss_dst_tag), 32'h7);
    chk("first_count", 32'(count), 32'd1);
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    #1;
    chk("first_drained_count", 32'(count), 32'd0);
    chk("first_drained_valid", 32'(iss_valid), 32'd0);

    // Age order: A, B, then C lands in a lower slot than B but must still issue after it.
    disp(16'hA000, 16'h0010, 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0, 4'h1);
    cyc();
    disp(16'hB000, 16'h0011, 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0, 4'h2);
    cyc();
    idle();
    #1;
    chk("age_count2", 32'(count), 32'd2);
    chk("age_first_A", 32'(iss_pc), 32'h0010);
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    disp(16'hC000, 16'h0012, 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0, 4'h3);
    #1;
    chk("age_then_B", 32'(iss_pc), 32'h0011);
    cyc();
    idle();
    #1;
    chk("age_count_BC", 32'(count), 32'd2);
    chk("age_B_before_C", 32'(iss_pc), 32'h0011);
    iss_ready = 1'b1;
    cyc();
    #1;
    chk("age_then_C", 32'(iss_pc), 32'h0012);
    cyc();
    iss_ready = 1'b0;
    #1;
    chk("age_drained", 32'(count), 32'd0);

    // Wakeup via writeback, including an unrelated tag and a late duplicate.
    disp(16'h3000, 16'h0030, 4'h5, 1'b0, 16'h0, 4'h9, 1'b1, 16'h0909, 4'h4);
    cyc();
    idle();
    #1;
    chk("wake_wait_valid", 32'(iss_valid), 32'd0);
    chk("wake_wait_count", 32'(count), 32'd1);
    wb(4'h6, 16'hDEAD);
    cyc();
    idle();
    #1;
    chk("wake_other_tag", 32'(iss_valid), 32'd0);
    wb(4'h5, 16'hBEEF);
    #1;
    chk("wake_no_same_cycle", 32'(iss_valid), 32'd0);
    cyc();
    idle();
    #1;
    chk("wake_valid", 32'(iss_valid), 32'd1);
    chk("wake_r1data", 32'(iss_r1data), 32'hBEEF);
    chk("wake_r2data", 32'(iss_r2data), 32'h0909);
    wb(4'h5, 16'h1111);
    cyc();
    idle();
    #1;
    chk("wake_no_overwrite", 32'(iss_r1data), 32'hBEEF);
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    #1;
    chk("wake_drained", 32'(count), 32'd0);

    // Fill to capacity under backpressure.
    for (int i = 0; i < 4; i++) begin
      disp(16'h4000 + 16'(i), 16'h0040 + 16'(i), 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0, 4'(i));
      cyc();
    end
    idle();
    #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_disp_ready", 32'(disp_ready), 32'd0);
    chk("full_iss_pc", 32'(iss_pc), 32'h0040);
    disp(16'h4FFF, 16'h04FF, 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0, 4'h0);
    cyc();
    #1;
    chk("full_hold_count", 32'(count), 32'd4);
    chk("full_stable_pc", 32'(iss_pc), 32'h0040);
    chk("full_stable_insn", 32'(iss_insn), 32'h4000);
    iss_ready = 1'b1;
    #1;
    chk("full_issue_no_dispatch", 32'(disp_ready), 32'd0);
    cyc();
    iss_ready = 1'b0;
    idle();
    #1;
    chk("after_issue_count", 32'(count), 32'd3);
    chk("after_issue_ready", 32'(disp_ready), 32'd1);
    chk("after_issue_pc", 32'(iss_pc), 32'h0041);
    iss_ready = 1'b1;
    repeat (3) cyc();
    iss_ready = 1'b0;
    #1;
    chk("full_drained", 32'(count), 32'd0);

    // Dispatch bypass from a same-cycle writeback.
    disp(16'h5000, 16'h0050, 4'h1, 1'b1, 16'h0011, 4'h3, 1'b0, 16'h0000, 4'h5);
    wb(4'h3, 16'h0042);
    #1;
    chk("bypass_empty", 32'(iss_valid), 32'd0);
    cyc();
    idle();
    #1;
    chk("bypass_valid", 32'(iss_valid), 32'd1);
    chk("bypass_r2data", 32'(iss_r2data), 32'h0042);
    chk("bypass_r1data", 32'(iss_r1data), 32'h0011);
    iss_ready = 1'b1;
    cyc();
    iss_ready = 1'b0;
    #1;
    chk("bypass_drained", 32'(count), 32'd0);

    // Flush with a concurrent dispatch attempt.
    for (int i = 0; i < 3; i++) begin
      disp(16'h6000 + 16'(i), 16'h0060 + 16'(i), 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0, 4'h0);
      cyc();
    end
    idle();
    #1;
    chk("flush_pre_count", 32'(count), 32'd3);
    disp(16'h6FFF, 16'h06FF, 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0, 4'h0);
    flush = 1'b1;
    #1;
    chk("flush_iss_valid", 32'(iss_valid), 32'd0);
    chk("flush_disp_ready", 32'(disp_ready), 32'd0);
    cyc();
    idle();
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_dropped", 32'(iss_valid), 32'd0);

    // Reset in the middle of operation.
    disp(16'h7100, 16'h0071, 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0, 4'h0);
    cyc();
    disp(16'h7200, 16'h0072, 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0, 4'h0);
    cyc();
    idle();
    #1;
    chk("midrst_pre_count", 32'(count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_iss_valid", 32'(iss_valid), 32'd0);
    chk("midrst_disp_ready", 32'(disp_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    disp(16'h7000, 16'h0070, 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0, 4'h0);
    cyc();
    idle();
    #1;
    chk("postrst_count", 32'(count), 32'd1);
    chk("postrst_insn", 32'(iss_insn), 32'h7000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
